// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared parameters and strobe bundle for the shift-add multiplier
package mult_pkg;

  localparam int MULT_N = 8;

  // Lower value wins when the controller raises more than one data strobe.
  localparam int PRIO_LOAD  = 0;
  localparam int PRIO_ADD   = 1;
  localparam int PRIO_SHIFT = 2;
  localparam int PRIO_DECRE = 3;

  typedef struct packed {
    logic load;
    logic add;
    logic shift;
    logic decre;
    logic ready;
  } strobe_t;

endpackage

// File: rtl/mult_iter_counter.sv
// rtl/mult_iter_counter.sv - iteration counter P: load N, saturating decrement, zero flag
module mult_iter_counter #(
  parameter int N  = 8,
  parameter int PW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          decre_i,
  output logic [PW-1:0] p_o,
  output logic          zero_o,
  output logic          underflow_o
);

  logic [PW-1:0] p_q, p_d;

  assign zero_o      = (p_q == '0);
  assign underflow_o = decre_i && !load_i && zero_o;
  assign p_o         = p_q;

  always_comb begin
    p_d = p_q;
    if (load_i) begin
      p_d = PW'(N);
    end else if (decre_i && !zero_o) begin
      p_d = p_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/mult_shiftadd_datapath.sv
// rtl/mult_shiftadd_datapath.sv - M/A/C/Q registers and product latch driven by controller strobes
module mult_shiftadd_datapath
  import mult_pkg::*;
#(
  parameter int N  = MULT_N,
  parameter int PW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_regs,
  input  logic           add_regs,
  input  logic           shift_regs,
  input  logic           decre_p,
  input  logic           ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           zero,
  output logic           pulso,
  output logic [2*N-1:0] product,
  output logic           product_valid,
  output logic           err
);

  strobe_t stb;
  logic [N-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
  logic           c_q, c_d;
  logic [2*N-1:0] product_q, product_d;
  logic           pv_q, pv_d, err_q, err_d;
  logic           do_load, do_add, do_shift, do_decre, multi, underflow;
  logic [2:0]     n_strobes;
  logic [PW-1:0]  p;

  assign stb = '{load: load_regs, add: add_regs, shift: shift_regs,
                 decre: decre_p, ready: ready};

  assign n_strobes = 3'(stb.load) + 3'(stb.add) + 3'(stb.shift) + 3'(stb.decre);
  assign multi     = (n_strobes > 3'd1);
  assign do_load   = stb.load;
  assign do_add    = stb.add   && !stb.load;
  assign do_shift  = stb.shift && !stb.load && !stb.add;
  assign do_decre  = stb.decre && !stb.load && !stb.add && !stb.shift;

  mult_iter_counter #(.N(N), .PW(PW)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .load_i      (do_load),
    .decre_i     (do_decre),
    .p_o         (p),
    .zero_o      (zero),
    .underflow_o (underflow)
  );

  always_comb begin
    a_d       = a_q;
    c_d       = c_q;
    q_d       = q_q;
    m_d       = m_q;
    product_d = product_q;
    pv_d      = pv_q;
    err_d     = err_q | multi | underflow;
    if (do_load) begin
      m_d  = multiplicand;
      q_d  = multiplier;
      a_d  = '0;
      c_d  = 1'b0;
      pv_d = 1'b0;
    end else if (do_add) begin
      {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
    end else if (do_shift) begin
      {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
    end
    // Capture uses pre-edge registers, so it composes with any data strobe.
    if (stb.ready) begin
      product_d = {a_q, q_q};
      pv_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q       <= '0;
      c_q       <= 1'b0;
      q_q       <= '0;
      m_q       <= '0;
      product_q <= '0;
      pv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      c_q       <= c_d;
      q_q       <= q_d;
      m_q       <= m_d;
      product_q <= product_d;
      pv_q      <= pv_d;
      err_q     <= err_d;
    end
  end

  assign pulso         = q_q[0];
  assign product       = product_q;
  assign product_valid = pv_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mult_shiftadd_datapath.sv
// tb/tb_mult_shiftadd_datapath.sv - directed self-checking bench for the multiplier datapath
module tb_mult_shiftadd_datapath;
  import mult_pkg::*;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_regs, add_regs, shift_regs, decre_p, ready;
  logic [N-1:0]   multiplicand, multiplier;
  logic           zero, pulso, product_valid, err;
  logic [2*N-1:0] product;

  int total = 0;
  int bad   = 0;

  logic [3:0] pseq;
  logic       saw_carry, carry_shift_ok;

  mult_shiftadd_datapath #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_regs     (load_regs),
    .add_regs      (add_regs),
    .shift_regs    (shift_regs),
    .decre_p       (decre_p),
    .ready         (ready),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .zero          (zero),
    .pulso         (pulso),
    .product       (product),
    .product_valid (product_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input strobe_t s);
    load_regs  = s.load;
    add_regs   = s.add;
    shift_regs = s.shift;
    decre_p    = s.decre;
    ready      = s.ready;
    @(posedge clk);
    #1;
    {load_regs, add_regs, shift_regs, decre_p, ready} = '0;
  endtask

  task automatic do_load(input logic [N-1:0] mc, input logic [N-1:0] mp);
    multiplicand = mc;
    multiplier   = mp;
    apply('{load: 1'b1, default: 1'b0});
  endtask

  task automatic iterate(input int iters);
    for (int i = 0; i < iters; i++) begin
      if (i < 4) pseq[i] = pulso;
      if (pulso) begin
        apply('{add: 1'b1, default: 1'b0});
        if (dut.c_q) begin
          saw_carry = 1'b1;
          apply('{shift: 1'b1, default: 1'b0});
          if (!dut.a_q[N-1]) carry_shift_ok = 1'b0;
        end else begin
          apply('{shift: 1'b1, default: 1'b0});
        end
      end else begin
        apply('{shift: 1'b1, default: 1'b0});
      end
      apply('{decre: 1'b1, default: 1'b0});
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_a"},   32'(dut.a_q), 0);
    check({tag, "_c"},   32'(dut.c_q), 0);
    check({tag, "_q"},   32'(dut.q_q), 0);
    check({tag, "_m"},   32'(dut.m_q), 0);
    check({tag, "_p"},   32'(dut.p), 0);
    check({tag, "_prd"}, 32'(product), 0);
    check({tag, "_zero"}, 32'(zero), 1);
    check({tag, "_pulso"}, 32'(pulso), 0);
    check({tag, "_pv"},  32'(product_valid), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    {load_regs, add_regs, shift_regs, decre_p, ready} = '0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    pseq = '0;
    saw_carry = 1'b0;
    carry_shift_ok = 1'b1;

    // Reset with random strobes and operands asserted.
    rst = 1'b0;
    {load_regs, add_regs, shift_regs, decre_p, ready} = 5'($urandom) | 5'b10000;
    @(posedge clk);
    #1;
    {load_regs, add_regs, shift_regs, decre_p, ready} = '0;
    rst = 1'b1;
    check_cleared("rst");

    // 13 x 11
    do_load(8'd13, 8'd11);
    check("load_zero", 32'(zero), 0);
    check("load_p", 32'(dut.p), 8);
    iterate(N);
    check("m13_pulso_seq", 32'(pseq), 32'hB);
    check("m13_zero", 32'(zero), 1);
    apply('{ready: 1'b1, default: 1'b0});
    check("m13_prod", 32'(product), 32'h008F);
    check("m13_pv", 32'(product_valid), 1);
    check("m13_err", 32'(err), 0);
    do_load(8'd1, 8'd1);
    check("reload_prod_held", 32'(product), 32'h008F);
    check("reload_pv", 32'(product_valid), 0);

    // 255 x 255 exercises the carry bit.
    do_load(8'd255, 8'd255);
    iterate(N);
    apply('{ready: 1'b1, default: 1'b0});
    check("m255_prod", 32'(product), 32'hFE01);
    check("m255_saw_carry", 32'(saw_carry), 1);
    check("m255_carry_into_a7", 32'(carry_shift_ok), 1);
    check("m255_err", 32'(err), 0);

    // 200 x 0: no adds ever.
    do_load(8'd200, 8'd0);
    pseq = '1;
    iterate(4);
    check("m0_pulso_seq", 32'(pseq), 0);
    iterate(N - 4);
    check("m0_a", 32'(dut.a_q), 0);
    apply('{ready: 1'b1, default: 1'b0});
    check("m0_prod", 32'(product), 0);
    check("m0_pv", 32'(product_valid), 1);
    do_load(8'd200, 8'd0);
    check("m0_reload_pv", 32'(product_valid), 0);
    check("m0_reload_prod", 32'(product), 0);

    // Load and add together: load wins, err latches.
    apply('{add: 1'b1, default: 1'b0});
    multiplicand = 8'd5;
    multiplier   = 8'd3;
    apply('{load: 1'b1, add: 1'b1, default: 1'b0});
    check("la_err", 32'(err), 1);
    check("la_a", 32'(dut.a_q), 0);
    check("la_c", 32'(dut.c_q), 0);
    check("la_p", 32'(dut.p), 8);
    check("la_m", 32'(dut.m_q), 5);
    check("la_q", 32'(dut.q_q), 3);
    apply('{shift: 1'b1, default: 1'b0});
    check("err_sticky", 32'(err), 1);

    // Decrement at P == 0 after reset.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("pre_dec_err", 32'(err), 0);
    apply('{decre: 1'b1, default: 1'b0});
    check("dec0_p", 32'(dut.p), 0);
    check("dec0_zero", 32'(zero), 1);
    check("dec0_err", 32'(err), 1);

    // Reset in the middle of a multiplication.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_load(8'd13, 8'd11);
    iterate(3);
    rst = 1'b0;
    {load_regs, add_regs, shift_regs, decre_p, ready} = 5'b11111;
    @(posedge clk);
    #1;
    {load_regs, add_regs, shift_regs, decre_p, ready} = '0;
    rst = 1'b1;
    check_cleared("midrst");
    do_load(8'd13, 8'd11);
    iterate(N);
    apply('{ready: 1'b1, default: 1'b0});
    check("after_rst_prod", 32'(product), 32'h008F);
    check("after_rst_pv", 32'(product_valid), 1);
    check("after_rst_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
